md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_pkg.sv | 35 +++
 rtl/md_unit_if.sv | 33 +++
 rtl/md_unit.sv | 112 +++++++++++
 tb/tb_md_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg
// Shared encodings for the multiply/divide unit: MDOp and MDRead codes,
// bus widths and the per-operation busy latencies. The decoder, the hazard
// unit and md_unit all import this package.
package md_pkg;

  localparam int OP_W = 4;
  localparam int RD_W = 2;

  typedef enum logic [OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  typedef enum logic [RD_W-1:0] {
    RD_NONE = 2'd0,
    RD_HI   = 2'd1,
    RD_LO   = 2'd2
  } md_read_e;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  // True for the four op codes that occupy the unit for a multi-cycle run.
  function automatic logic is_long_op(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if
// Pipeline-side bundle for the multiply/divide unit.
//   req    : flush of the E-stage instruction (op has no effect)
//   MDOp   : operation code (md_op_e)
//   MDRead : HI/LO read select (md_read_e)
//   A, B   : forwarded rs / rt operands
//   start  : a mult/div is accepted this cycle
//   busy   : a mult/div is in flight
//   MDOut  : committed HI or LO, or 0
// master = E stage / pipeline, slave = md_unit.
interface md_unit_if;
  import md_pkg::*;

  logic            req;
  logic [OP_W-1:0] MDOp;
  logic [RD_W-1:0] MDRead;
  logic [31:0]     A;
  logic [31:0]     B;
  logic            start;
  logic            busy;
  logic [31:0]     MDOut;

  modport master (
    output req, MDOp, MDRead, A, B,
    input  start, busy, MDOut
  );

  modport slave (
    input  req, MDOp, MDRead, A, B,
    output start, busy, MDOut
  );

endinterface

// File: rtl/md_unit.sv
// md_unit
// MIPS-style HI/LO multiply/divide unit with a fixed-latency busy window.
// The result is computed combinationally at the start edge and parked in
// temporaries; it only reaches HI/LO when the down-counter expires, so the
// pipeline sees the same timing as a real iterative divider.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : md_unit_if.slave (req, MDOp, MDRead, A, B -> start, busy, MDOut)
module md_unit
  import md_pkg::*;
(
  input logic      clk,
  input logic      reset,
  md_unit_if.slave bus
);

  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_tmp_q, lo_tmp_q;
  logic [3:0]  cnt_q;
  logic        busy_q;

  logic [31:0] hi_calc, lo_calc;
  logic [3:0]  cnt_load;
  logic [63:0] prod_s, prod_u;
  logic        start_w;

  assign start_w = is_long_op(bus.MDOp) && !bus.req && !busy_q;

  assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) *
                  $signed({{32{bus.B[31]}}, bus.B});
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // Result and latency for the op being offered this cycle. A zero divisor
  // reloads the current HI/LO so the commit at the end is a no-op. The
  // signed MIN/-1 case is pinned explicitly because it overflows.
  always_comb begin
    hi_calc  = hi_q;
    lo_calc  = lo_q;
    cnt_load = MULT_CYCLES;
    case (bus.MDOp)
      MD_MULT:  {hi_calc, lo_calc} = prod_s;
      MD_MULTU: {hi_calc, lo_calc} = prod_u;
      MD_DIV: begin
        cnt_load = DIV_CYCLES;
        if (bus.B != 32'd0) begin
          if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
            lo_calc = 32'h8000_0000;
            hi_calc = 32'd0;
          end else begin
            lo_calc = $signed(bus.A) / $signed(bus.B);
            hi_calc = $signed(bus.A) % $signed(bus.B);
          end
        end
      end
      MD_DIVU: begin
        cnt_load = DIV_CYCLES;
        if (bus.B != 32'd0) begin
          lo_calc = bus.A / bus.B;
          hi_calc = bus.A % bus.B;
        end
      end
      default: ;
    endcase
  end

  // State update: an accepted op loads the temporaries and counter; an
  // in-flight op counts down and commits on the count of 1 regardless of
  // req; mthi/mtlo only land when the unit is idle and not flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_tmp_q <= 32'd0;
      lo_tmp_q <= 32'd0;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
    end else if (start_w) begin
      hi_tmp_q <= hi_calc;
      lo_tmp_q <= lo_calc;
      cnt_q    <= cnt_load;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q == 4'd1) begin
        hi_q   <= hi_tmp_q;
        lo_q   <= lo_tmp_q;
        cnt_q  <= 4'd0;
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end else if (!bus.req) begin
      if (bus.MDOp == MD_MTHI) hi_q <= bus.A;
      if (bus.MDOp == MD_MTLO) lo_q <= bus.A;
    end
  end

  // Reads see only committed registers, so a same-cycle mthi/mtlo still
  // shows the old value.
  always_comb begin
    bus.MDOut = 32'd0;
    case (bus.MDRead)
      RD_HI:   bus.MDOut = hi_q;
      RD_LO:   bus.MDOut = lo_q;
      default: bus.MDOut = 32'd0;
    endcase
  end

  assign bus.start = start_w;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit
// Scoreboard bench for md_unit. Each stimulus cycle pushes its expected
// start/busy/MDOut into a queue; a monitor on the falling edge pops and
// compares against the DUT. Expected results are hand-computed constants.
module tb_md_unit;
  import md_pkg::*;

  logic clk;
  logic reset;

  md_unit_if bus ();

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        exp_start;
    logic        exp_busy;
    logic [31:0] exp_out;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic [31:0] m_hi, m_lo;

  // Compares one scoreboard entry against the live DUT outputs.
  task automatic checkOutput(input exp_t e);
    tests_run++;
    if (bus.start !== e.exp_start) begin
      tests_failed++;
      $display("[TB] FAIL %s start: got %b expected %b", e.name, bus.start, e.exp_start);
    end
    tests_run++;
    if (bus.busy !== e.exp_busy) begin
      tests_failed++;
      $display("[TB] FAIL %s busy: got %b expected %b", e.name, bus.busy, e.exp_busy);
    end
    tests_run++;
    if (bus.MDOut !== e.exp_out) begin
      tests_failed++;
      $display("[TB] FAIL %s MDOut: got %h expected %h", e.name, bus.MDOut, e.exp_out);
    end
  endtask

  // Monitor: consumes expectations mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
  end

  // Drives one cycle of inputs, queues its expectation, advances a cycle.
  task automatic applyStimulus(input logic rst, input logic [3:0] op,
                               input logic [1:0] rd, input logic [31:0] a,
                               input logic [31:0] b, input logic rq,
                               input logic e_start, input logic e_busy,
                               input logic [31:0] e_out, input string name);
    exp_t e;
    reset      = rst;
    bus.MDOp   = op;
    bus.MDRead = rd;
    bus.A      = a;
    bus.B      = b;
    bus.req    = rq;
    e.name      = name;
    e.exp_start = e_start;
    e.exp_busy  = e_busy;
    e.exp_out   = e_out;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Full op: start cycle, lat busy cycles, then read back HI and LO.
  task automatic runOp(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int lat,
                       input logic [31:0] new_hi, input logic [31:0] new_lo,
                       input string name);
    applyStimulus(1'b0, op, RD_HI, a, b, 1'b0, 1'b1, 1'b0, m_hi, {name, " start"});
    for (int i = 1; i <= lat; i++) begin
      if (i % 2 == 1)
        applyStimulus(1'b0, MD_NONE, RD_LO, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, m_lo,
                      $sformatf("%s busy%0d", name, i));
      else
        applyStimulus(1'b0, MD_NONE, RD_HI, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, m_hi,
                      $sformatf("%s busy%0d", name, i));
    end
    m_hi = new_hi;
    m_lo = new_lo;
    applyStimulus(1'b0, MD_NONE, RD_HI, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, m_hi, {name, " hi"});
    applyStimulus(1'b0, MD_NONE, RD_LO, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, m_lo, {name, " lo"});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset      = 1'b1;
    bus.req    = 1'b0;
    bus.MDOp   = MD_NONE;
    bus.MDRead = RD_NONE;
    bus.A      = 32'd0;
    bus.B      = 32'd0;
    m_hi       = 32'd0;
    m_lo       = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    applyStimulus(1'b0, MD_NONE, RD_HI, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "reset hi");
    applyStimulus(1'b0, MD_NONE, RD_LO, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "reset lo");
    applyStimulus(1'b0, MD_MULT, RD_NONE, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0, 32'd0, "req blocks start");
    applyStimulus(1'b0, MD_NONE, RD_NONE, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "no busy after req");

    runOp(MD_MULT,  32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult -2*3");
    runOp(MD_MULTU, 32'hFFFF_FFFF, 32'd2,        5,  32'h0000_0001, 32'hFFFF_FFFE, "multu");
    runOp(MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0000_0000, 32'h0000_0001, "mult -1*-1");
    runOp(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, "multu max");
    runOp(MD_DIV,   32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");
    runOp(MD_DIVU,  32'd5,         32'd0,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "divu by 0");
    runOp(MD_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, "div 7/-2");
    runOp(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, "div min/-1");
    runOp(MD_DIVU,  32'd100,       32'd7,        10, 32'h0000_0002, 32'h0000_000E, "divu 100/7");

    // mthi flushed, then mthi/mtlo live with same-cycle read of old value.
    applyStimulus(1'b0, MD_MTHI, RD_HI, 32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b0, m_hi, "mthi req");
    applyStimulus(1'b0, MD_NONE, RD_HI, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, m_hi, "mthi req suppressed");
    applyStimulus(1'b0, MD_MTHI, RD_HI, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0, m_hi, "mthi old value");
    m_hi = 32'h1234_5678;
    applyStimulus(1'b0, MD_NONE, RD_HI, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, m_hi, "mthi written");
    applyStimulus(1'b0, MD_MTLO, RD_LO, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0, 1'b0, m_lo, "mtlo old value");
    m_lo = 32'hCAFE_F00D;
    applyStimulus(1'b0, MD_NONE, RD_LO, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, m_lo, "mtlo written");

    // Ops presented while busy are ignored.
    applyStimulus(1'b0, MD_MULT, RD_HI, 32'd3, 32'd4, 1'b0, 1'b1, 1'b0, m_hi, "mult 3*4 start");
    applyStimulus(1'b0, MD_NONE, RD_LO, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, m_lo, "mult 3*4 busy1");
    applyStimulus(1'b0, MD_MTLO, RD_LO, 32'h0000_DEAD, 32'd0, 1'b0, 1'b0, 1'b1, m_lo, "mtlo while busy");
    applyStimulus(1'b0, MD_MULT, RD_LO, 32'd5, 32'd5, 1'b0, 1'b0, 1'b1, m_lo, "mult while busy");
    applyStimulus(1'b0, MD_NONE, RD_HI, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, m_hi, "mult 3*4 busy4 req");
    applyStimulus(1'b0, MD_NONE, RD_LO, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, m_lo, "mult 3*4 busy5");
    m_hi = 32'd0;
    m_lo = 32'd12;
    applyStimulus(1'b0, MD_NONE, RD_HI, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, m_hi, "mult 3*4 hi");
    applyStimulus(1'b0, MD_NONE, RD_LO, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, m_lo, "mult 3*4 lo");

    // Reset mid-divide, with an mthi in the same cycle to check priority.
    applyStimulus(1'b0, MD_DIV, RD_LO, 32'd100, 32'd3, 1'b0, 1'b1, 1'b0, m_lo, "div abort start");
    for (int i = 1; i <= 3; i++)
      applyStimulus(1'b0, MD_NONE, RD_LO, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, m_lo,
                    $sformatf("div abort busy%0d", i));
    applyStimulus(1'b1, MD_MTHI, RD_HI, 32'h0000_0055, 32'd0, 1'b0, 1'b0, 1'b1, m_hi, "reset cycle");
    m_hi = 32'd0;
    m_lo = 32'd0;
    applyStimulus(1'b0, MD_NONE, RD_LO, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, m_lo, "after reset lo");
    applyStimulus(1'b0, MD_NONE, RD_HI, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, m_hi, "after reset hi");
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b0, MD_NONE, (i % 2 == 0) ? RD_LO : RD_HI, 32'd0, 32'd0, 1'b0,
                    1'b0, 1'b0, 32'd0, $sformatf("no late update %0d", i));

    @(negedge clk);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard drain: got %0d expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
